// File: rtl/dm_sba_bus_bridge_pkg.sv
// rtl/dm_sba_bus_bridge_pkg.sv - shared types for the DM system-bus-access bridge
package dm;

  localparam int unsigned SbaBusWidth = 32;
  localparam int unsigned SbaBeWidth  = SbaBusWidth / 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    REQ   = 2'd1,
    RESP  = 2'd2,
    DRAIN = 2'd3
  } sba_bridge_state_e;

  typedef struct packed {
    logic [SbaBusWidth-1:0] addr;
    logic                   we;
    logic [SbaBusWidth-1:0] wdata;
    logic [SbaBeWidth-1:0]  be;
  } sba_bridge_req_t;

endpackage

// File: rtl/dm_sba_bus_bridge.sv
// rtl/dm_sba_bus_bridge.sv - DM SBA req/gnt to registered valid/ready A/D bus bridge
// Optional hung-transfer abort enabled by DM_SBA_BRIDGE_TIMEOUT_EN.
module dm_sba_bus_bridge
  import dm::*;
#(
  parameter int unsigned BusWidth      = 32,
  parameter int unsigned TimeoutCycles = 1024
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  dm_req_i,
  input  logic [BusWidth-1:0]   dm_add_i,
  input  logic                  dm_we_i,
  input  logic [BusWidth-1:0]   dm_wdata_i,
  input  logic [BusWidth/8-1:0] dm_be_i,
  output logic                  dm_gnt_o,
  output logic                  dm_r_valid_o,
  output logic                  dm_r_err_o,
  output logic                  dm_r_other_err_o,
  output logic [BusWidth-1:0]   dm_r_rdata_o,
  output logic                  a_valid_o,
  input  logic                  a_ready_i,
  output logic [BusWidth-1:0]   a_addr_o,
  output logic                  a_we_o,
  output logic [BusWidth-1:0]   a_wdata_o,
  output logic [BusWidth/8-1:0] a_be_o,
  input  logic                  d_valid_i,
  output logic                  d_ready_o,
  input  logic [BusWidth-1:0]   d_rdata_i,
  input  logic                  d_err_i,
  output logic                  busy_o
);

  sba_bridge_state_e state_q, state_d;
  sba_bridge_req_t   req_q;
  logic              r_valid_q, r_err_q;
  logic [BusWidth-1:0] r_rdata_q;
  logic              load_req, rsp_done, abort, expired;

`ifdef DM_SBA_BRIDGE_TIMEOUT_EN
  localparam int unsigned CntW = $clog2(TimeoutCycles + 1);
  logic [CntW-1:0] cnt_q;
  logic            r_other_q;

  assign expired = (cnt_q == CntW'(TimeoutCycles - 1));

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else if (load_req) begin
      cnt_q <= '0;
    end else if (state_q == REQ || state_q == RESP) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  assign dm_r_other_err_o = r_other_q;
`else
  logic unused_timeout;
  assign unused_timeout   = ^TimeoutCycles;
  assign expired          = 1'b0;
  assign dm_r_other_err_o = 1'b0;
`endif

  always_comb begin
    state_d   = state_q;
    dm_gnt_o  = 1'b0;
    a_valid_o = 1'b0;
    d_ready_o = 1'b0;
    load_req  = 1'b0;
    rsp_done  = 1'b0;
    abort     = 1'b0;
    unique case (state_q)
      IDLE: begin
        dm_gnt_o = dm_req_i & ~rst_i;
        if (dm_req_i) begin
          load_req = 1'b1;
          state_d  = REQ;
        end
      end
      REQ: begin
        a_valid_o = 1'b1;
        // A handshake counts as progress, so it beats a same-cycle expiry.
        if (a_ready_i) begin
          state_d = RESP;
        end else if (expired) begin
          abort   = 1'b1;
          state_d = IDLE;
        end
      end
      RESP: begin
        d_ready_o = 1'b1;
        if (d_valid_i) begin
          rsp_done = 1'b1;
          state_d  = IDLE;
        end else if (expired) begin
          abort   = 1'b1;
          state_d = DRAIN;
        end
      end
      DRAIN: begin
        // Swallow the late response of an aborted transfer.
        d_ready_o = 1'b1;
        if (d_valid_i) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q   <= IDLE;
      req_q     <= '0;
      r_valid_q <= 1'b0;
      r_err_q   <= 1'b0;
      r_rdata_q <= '0;
`ifdef DM_SBA_BRIDGE_TIMEOUT_EN
      r_other_q <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      r_valid_q <= 1'b0;
      if (load_req) begin
        req_q.addr  <= dm_add_i;
        req_q.we    <= dm_we_i;
        req_q.wdata <= dm_we_i ? dm_wdata_i : '0;
        req_q.be    <= dm_be_i;
      end
      if (rsp_done) begin
        r_valid_q <= 1'b1;
        r_rdata_q <= req_q.we ? '0 : d_rdata_i;
        r_err_q   <= d_err_i;
`ifdef DM_SBA_BRIDGE_TIMEOUT_EN
        r_other_q <= 1'b0;
`endif
      end else if (abort) begin
        r_valid_q <= 1'b1;
        r_rdata_q <= '0;
        r_err_q   <= 1'b0;
`ifdef DM_SBA_BRIDGE_TIMEOUT_EN
        r_other_q <= 1'b1;
`endif
      end
    end
  end

  assign dm_r_valid_o = r_valid_q;
  assign dm_r_err_o   = r_err_q;
  assign dm_r_rdata_o = r_rdata_q;
  assign a_addr_o     = req_q.addr;
  assign a_we_o       = req_q.we;
  assign a_wdata_o    = req_q.wdata;
  assign a_be_o       = req_q.be;
  assign busy_o       = (state_q != IDLE);

endmodule

// File: tb/tb_dm_sba_bus_bridge.sv
// tb/tb_dm_sba_bus_bridge.sv - self-checking bench for dm_sba_bus_bridge
module tb_dm_sba_bus_bridge;

  logic        clk, rst;
  logic        dm_req, dm_we;
  logic [31:0] dm_add, dm_wdata;
  logic [3:0]  dm_be;
  logic        dm_gnt_o, dm_r_valid_o, dm_r_err_o, dm_r_other_err_o;
  logic [31:0] dm_r_rdata_o;
  logic        a_valid_o, a_ready, a_we_o;
  logic [31:0] a_addr_o, a_wdata_o;
  logic [3:0]  a_be_o;
  logic        d_valid, d_ready_o, d_err, busy_o;
  logic [31:0] d_rdata;

  dm_sba_bus_bridge #(.BusWidth(32), .TimeoutCycles(8)) dut (
    .clk_i(clk), .rst_i(rst),
    .dm_req_i(dm_req), .dm_add_i(dm_add), .dm_we_i(dm_we),
    .dm_wdata_i(dm_wdata), .dm_be_i(dm_be),
    .dm_gnt_o(dm_gnt_o), .dm_r_valid_o(dm_r_valid_o), .dm_r_err_o(dm_r_err_o),
    .dm_r_other_err_o(dm_r_other_err_o), .dm_r_rdata_o(dm_r_rdata_o),
    .a_valid_o(a_valid_o), .a_ready_i(a_ready), .a_addr_o(a_addr_o),
    .a_we_o(a_we_o), .a_wdata_o(a_wdata_o), .a_be_o(a_be_o),
    .d_valid_i(d_valid), .d_ready_o(d_ready_o), .d_rdata_i(d_rdata),
    .d_err_i(d_err), .busy_o(busy_o)
  );

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
    int          a_wait;
    int          d_wait;
    logic        d_early;
    logic [31:0] rdata;
    logic        derr;
    logic [31:0] exp_rdata;
    logic        exp_err;
  } vec_t;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    logic        other;
    int          cyc;
  } exp_t;

  exp_t sb[$];
  vec_t vecs[$];
  int   n_cmp = 0;
  int   n_err = 0;
  int   n_rvalid = 0;
  int   cyc = 0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc++;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  always @(negedge clk) begin
    if (!rst && dm_r_valid_o) begin
      exp_t e;
      n_rvalid++;
      if (sb.size() == 0) begin
        check("unexpected_rvalid", 1'b1, 1'b0);
      end else begin
        e = sb.pop_front();
        check("r_rdata", dm_r_rdata_o, e.rdata);
        check("r_err", dm_r_err_o, e.err);
        check("r_other_err", dm_r_other_err_o, e.other);
        check("r_valid_cycle", cyc, e.cyc);
      end
    end
  end

  task automatic run_txn(input vec_t v);
    int c0;
    logic [31:0] ew;
    @(negedge clk);
    dm_req = 1'b1; dm_we = v.we; dm_add = v.addr; dm_wdata = v.wdata; dm_be = v.be;
    #1 check("gnt_idle", dm_gnt_o, 1'b1);
    c0 = cyc;
    sb.push_back('{v.exp_rdata, v.exp_err, 1'b0, c0 + 3 + v.a_wait + v.d_wait});
    ew = v.we ? v.wdata : 32'h0;
    @(negedge clk);
    dm_req = 1'b0; dm_add = ~v.addr; dm_wdata = ~v.wdata; dm_be = ~v.be;
    for (int i = 0; i <= v.a_wait; i++) begin
      a_ready = (i == v.a_wait);
      d_valid = v.d_early && (i < v.a_wait);
      d_err   = d_valid;
      d_rdata = 32'hBADB_AD00;
      #1 check("req_fields", {a_valid_o, d_ready_o, dm_gnt_o, a_addr_o, a_we_o, a_wdata_o, a_be_o},
                             {1'b1, 1'b0, 1'b0, v.addr, v.we, ew, v.be});
      @(negedge clk);
    end
    a_ready = 1'b0; d_valid = 1'b0; d_err = 1'b0;
    for (int i = 0; i < v.d_wait; i++) begin
      #1 check("resp_wait", {d_ready_o, busy_o, a_valid_o, dm_r_valid_o}, 4'b1100);
      @(negedge clk);
    end
    d_valid = 1'b1; d_rdata = v.rdata; d_err = v.derr;
    @(negedge clk);
    d_valid = 1'b0; d_err = 1'b0; d_rdata = 32'h0;
  endtask

  initial begin
    int c0, n0;
    vecs.push_back('{1'b0, 32'h1000_0040, 32'h0, 4'hF, 0, 0, 1'b0, 32'hDEAD_BEEF, 1'b0, 32'hDEAD_BEEF, 1'b0});
    vecs.push_back('{1'b1, 32'h2000_0000, 32'h1234_5678, 4'b0011, 5, 0, 1'b0, 32'hFFFF_FFFF, 1'b0, 32'h0, 1'b0});
    vecs.push_back('{1'b0, 32'h3000_0004, 32'h7777_7777, 4'hF, 1, 2, 1'b0, 32'h0BAD_F00D, 1'b1, 32'h0BAD_F00D, 1'b1});
    vecs.push_back('{1'b1, 32'h4000_0008, 32'hCAFE_BABE, 4'hF, 0, 3, 1'b0, 32'h1111_1111, 1'b1, 32'h0, 1'b1});
`ifndef DM_SBA_BRIDGE_TIMEOUT_EN
    vecs.push_back('{1'b0, 32'h5000_0010, 32'h0, 4'hF, 0, 40, 1'b0, 32'h0F0F_0F0F, 1'b0, 32'h0F0F_0F0F, 1'b0});
`endif
    vecs.push_back('{1'b0, 32'h6000_0020, 32'h0, 4'b1000, 3, 0, 1'b1, 32'h55AA_33CC, 1'b0, 32'h55AA_33CC, 1'b0});

    rst = 1'b1; dm_req = 1'b1; dm_we = 1'b0; dm_add = 32'hFFFF_FFFF; dm_wdata = 32'h0; dm_be = 4'h0;
    a_ready = 1'b0; d_valid = 1'b0; d_err = 1'b0; d_rdata = 32'h0;
    repeat (2) @(negedge clk);
    #1 check("reset_outputs", {dm_gnt_o, dm_r_valid_o, dm_r_err_o, dm_r_other_err_o, dm_r_rdata_o,
                               a_valid_o, a_addr_o, a_we_o, a_wdata_o, a_be_o, d_ready_o, busy_o}, 128'h0);
    dm_req = 1'b0;
    @(negedge clk);
    rst = 1'b0;

    foreach (vecs[k]) run_txn(vecs[k]);

    repeat (3) @(negedge clk);
    #1 check("rsp_hold", {dm_r_valid_o, dm_r_err_o, dm_r_other_err_o, dm_r_rdata_o},
                         {1'b0, 1'b0, 1'b0, 32'h55AA_33CC});

    // Back-to-back reads with dm_req held high.
    n0 = n_rvalid;
    @(negedge clk);
    dm_req = 1'b1; dm_we = 1'b0; dm_add = 32'hA000_0000;
    #1 check("b2b_gnt0", dm_gnt_o, 1'b1);
    c0 = cyc;
    sb.push_back('{32'h1111_AAAA, 1'b0, 1'b0, c0 + 3});
    @(negedge clk);
    dm_add = 32'hA000_0004; a_ready = 1'b1;
    #1 check("b2b_gnt_req", dm_gnt_o, 1'b0);
    @(negedge clk);
    a_ready = 1'b0; d_valid = 1'b1; d_rdata = 32'h1111_AAAA;
    #1 check("b2b_gnt_resp", dm_gnt_o, 1'b0);
    @(negedge clk);
    d_valid = 1'b0;
    #1 check("b2b_gnt_with_rvalid", {dm_gnt_o, dm_r_valid_o}, 2'b11);
    sb.push_back('{32'h2222_BBBB, 1'b0, 1'b0, c0 + 6});
    @(negedge clk);
    dm_req = 1'b0; a_ready = 1'b1;
    #1 check("b2b_addr2", a_addr_o, 32'hA000_0004);
    @(negedge clk);
    a_ready = 1'b0; d_valid = 1'b1; d_rdata = 32'h2222_BBBB;
    @(negedge clk);
    d_valid = 1'b0;
    repeat (2) @(negedge clk);
    check("b2b_pulses", n_rvalid - n0, 2);

    // Reset asserted while in RESP.
    n0 = n_rvalid;
    @(negedge clk);
    dm_req = 1'b1; dm_we = 1'b0; dm_add = 32'h7000_0000;
    @(negedge clk);
    dm_req = 1'b0; a_ready = 1'b1;
    @(negedge clk);
    a_ready = 1'b0;
    #1 check("pre_reset_resp", {busy_o, d_ready_o}, 2'b11);
    rst = 1'b1; dm_req = 1'b1;
    #1 check("reset_mid_outputs", {dm_gnt_o, dm_r_valid_o, dm_r_err_o, dm_r_other_err_o, dm_r_rdata_o,
                                   a_valid_o, a_addr_o, a_we_o, a_wdata_o, a_be_o, d_ready_o, busy_o}, 128'h0);
    @(negedge clk);
    rst = 1'b0; dm_req = 1'b0; d_valid = 1'b1; d_rdata = 32'h9999_9999;
    @(negedge clk);
    d_valid = 1'b0;
    repeat (8) @(negedge clk);
    #1 check("no_rvalid_after_reset", {n_rvalid - n0, 31'h0, busy_o}, 64'h0);

`ifdef DM_SBA_BRIDGE_TIMEOUT_EN
    // Abort in RESP, then drain the late response.
    n0 = n_rvalid;
    @(negedge clk);
    dm_req = 1'b1; dm_we = 1'b0; dm_add = 32'h8000_0000;
    #1 check("to_gnt", dm_gnt_o, 1'b1);
    c0 = cyc;
    sb.push_back('{32'h0, 1'b0, 1'b1, c0 + 9});
    @(negedge clk);
    dm_req = 1'b0; a_ready = 1'b1;
    @(negedge clk);
    a_ready = 1'b0;
    repeat (7) @(negedge clk);
    dm_req = 1'b1;
    #1 check("drain_state", {busy_o, d_ready_o, a_valid_o, dm_gnt_o}, 4'b1100);
    @(negedge clk);
    d_valid = 1'b1; d_rdata = 32'hDEAD_0000;
    #1 check("drain_gnt", dm_gnt_o, 1'b0);
    @(negedge clk);
    d_valid = 1'b0;
    #1 check("drain_exit", {busy_o, dm_gnt_o}, 2'b01);
    dm_req = 1'b0;
    @(negedge clk);
    check("drain_one_rvalid", n_rvalid - n0, 1);

    // Abort while a_ready is withheld.
    @(negedge clk);
    dm_req = 1'b1; dm_add = 32'h8000_0100;
    #1 c0 = cyc;
    sb.push_back('{32'h0, 1'b0, 1'b1, c0 + 9});
    @(negedge clk);
    dm_req = 1'b0;
    repeat (8) @(negedge clk);
    #1 check("req_abort_idle", {a_valid_o, busy_o}, 2'b00);
    repeat (2) @(negedge clk);
`endif

    repeat (3) @(negedge clk);
    check("scoreboard_empty", sb.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
